uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4: FIFO depth = 2^DEPTH_LOG2 bytes.
REQ-002 The block SHALL have parameter THRESH, default 8: fill level that raises the interrupt, legal range 1..2^DEPTH_LOG2.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 32'd434000: idle cycles before a timeout, legal range >= 1.
REQ-004 clk_50m_i  input  1: the single clock; all logic on the rising edge.
REQ-005 rst_n_i  input  1: reset, asynchronous and active-low.
REQ-006 din_8b_i  input  8: received byte from the UART receiver.
REQ-007 din_valid_i  input  1: one-cycle push strobe qualifying din_8b_i.
REQ-008 rd_en_i  input  1: pop strobe from uart_control.
REQ-009 clr_i  input  1: synchronous flush of contents and flags.
REQ-010 dout_8b_o  output  8: head byte, first-word-fall-through.
REQ-011 empty_o  output  1: FIFO holds 0 bytes.
REQ-012 full_o  output  1: FIFO holds 2^DEPTH_LOG2 bytes.
REQ-013 count_o  output  DEPTH_LOG2+1: current fill level.
REQ-014 overflow_o  output  1: sticky flag, a byte was dropped.
REQ-015 timeout_o  output  1: sticky idle-timeout flag.
REQ-016 interrupt_o  output  1: level interrupt to uart_control.

Function
REQ-017 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read/write pointers that wrap from 2^DEPTH_LOG2-1 to 0; count_o is a separate registered counter.
REQ-018 A push SHALL be din_valid_i=1 with the FIFO not full, or with the FIFO full and rd_en_i=1 in the same cycle; the byte is written at wptr, and the new byte is visible one cycle later.
REQ-019 A pop SHALL be rd_en_i=1 with empty_o=0; dout_8b_o shows the byte at rptr combinationally while empty_o=0, and the next byte appears the cycle after the pop.
REQ-020 rd_en_i SHALL be ignored while empty_o=1: no pointer or count change, and no underflow flag.
REQ-021 Simultaneous push and pop SHALL advance both pointers and leave count_o unchanged, including at full and at count 1.
REQ-022 A push attempt when full without a pop SHALL drop the byte, leave the contents unchanged, and set overflow_o on the next cycle.
REQ-023 overflow_o SHALL stay set until clr_i or reset; later pops do not clear it.
REQ-024 dout_8b_o SHALL be don't-care while empty_o=1; the bench does not check it.
REQ-025 clr_i=1 SHALL zero the pointers, count_o, overflow_o, timeout_o and the idle counter on the next edge, and SHALL take priority over a push or pop in the same cycle.
REQ-026 interrupt_o SHALL equal (count_o >= THRESH) OR timeout_o, registered, asserting one cycle after the condition becomes true.
REQ-027 empty_o and full_o SHALL be decoded from the registered count_o.

Reset
REQ-028 While rst_n_i=0, the block SHALL force the pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, timeout_o=0, interrupt_o=0 and the idle counter=0, with no clock required.
REQ-029 A reset asserted mid-operation SHALL discard all stored bytes, and storage contents SHALL need no reset.
REQ-030 The first push SHALL be accepted on the first clock edge after rst_n_i deasserts.

Configuration
REQ-031 With macro UART_RX_FIFO_TIMEOUT_EN defined, a 32-bit idle counter SHALL increment each cycle while count_o>0, clear on any push, pop or clr_i, and hold at 0 while empty.
REQ-032 With the macro defined, timeout_o SHALL set when the idle counter reaches TIMEOUT_CYC, and SHALL clear on the next pop or on clr_i.
REQ-033 Without the macro, the idle counter SHALL be absent, timeout_o SHALL be tied to 0, and interrupt_o SHALL reduce to the threshold term only.

Verification
REQ-034 Push 0x11,0x22,0x33, one per 4 cycles, then pop 3 times -> dout_8b_o reads 0x11,0x22,0x33 in order, then empty_o=1 and count_o=0.
REQ-035 Push 16 bytes 0x00..0x0F (DEPTH_LOG2=4), then push 0xAA -> full_o=1, overflow_o=1, and the pop sequence is 0x00..0x0F with 0xAA absent.
REQ-036 With the FIFO full, push 0x55 and pop in the same cycle -> count_o stays 16, overflow_o=0, and 0x55 is the last byte popped.
REQ-037 Push 7 bytes, then 1 more -> interrupt_o=0 at count 7 and interrupt_o=1 one cycle after count reaches 8; pop 1 -> interrupt_o=0 one cycle later.
REQ-038 With UART_RX_FIFO_TIMEOUT_EN defined and TIMEOUT_CYC=20, push 1 byte and idle -> timeout_o=1 and interrupt_o=1 after 20 cycles; pop -> both clear. Without the macro -> timeout_o stays 0.
REQ-039 Push 5 bytes, then assert rst_n_i=0 asynchronously mid-push -> count_o=0 and empty_o=1 immediately; clr_i with 5 bytes held -> count_o=0 on the next edge.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream and status bundle between uart_rx_fifo (slave) and its consumer (master).
// The consumer pushes received bytes, pops them, and watches the fill/flag outputs.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          din_8b_i;
  logic                din_valid_i;
  logic                rd_en_i;
  logic                clr_i;
  logic [7:0]          dout_8b_o;
  logic                empty_o;
  logic                full_o;
  logic [DEPTH_LOG2:0] count_o;
  logic                overflow_o;
  logic                timeout_o;
  logic                interrupt_o;

  modport master (
    output din_8b_i, din_valid_i, rd_en_i, clr_i,
    input  dout_8b_o, empty_o, full_o, count_o, overflow_o, timeout_o, interrupt_o
  );

  modport slave (
    input  din_8b_i, din_valid_i, rd_en_i, clr_i,
    output dout_8b_o, empty_o, full_o, count_o, overflow_o, timeout_o, interrupt_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through byte buffer with sticky overflow and level interrupt.
// Define UART_RX_FIFO_TIMEOUT_EN to add the idle-timeout counter and timeout_o flag.
module uart_rx_fifo #(
  parameter int          DEPTH_LOG2  = 4,
  parameter int          THRESH      = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd434000
) (
  input logic           clk_50m_i,
  input logic           rst_n_i,
  uart_rx_fifo_if.slave bus
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT   = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] THRESH_CNT = THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: THRESH out of range 1..2^DEPTH_LOG2");
  end
  if (TIMEOUT_CYC == 32'd0) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYC must be at least 1");
  end

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  timeout;
  logic                  irq;
  logic                  empty;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = bus.rd_en_i && !empty;
  // At full, a same-cycle pop frees the slot the incoming byte takes.
  assign push_ok = bus.din_valid_i && (!full || bus.rd_en_i);
  assign drop    = bus.din_valid_i && full && !bus.rd_en_i;

  always_ff @(posedge clk_50m_i) begin
    if (push_ok && !bus.clr_i) begin
      mem[wptr] <= bus.din_8b_i;
    end
  end

  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.clr_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Saturates at TIMEOUT_CYC so the flag is raised exactly once per idle stretch.
  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt <= 32'd0;
      timeout  <= 1'b0;
    end else if (bus.clr_i) begin
      idle_cnt <= 32'd0;
      timeout  <= 1'b0;
    end else begin
      if (push_ok || pop_ok || empty) begin
        idle_cnt <= 32'd0;
      end else if (idle_cnt != TIMEOUT_CYC) begin
        idle_cnt <= idle_cnt + 32'd1;
        if (idle_cnt + 32'd1 == TIMEOUT_CYC) timeout <= 1'b1;
      end
      if (pop_ok) timeout <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq <= 1'b0;
    end else begin
      irq <= (count >= THRESH_CNT) || timeout;
    end
  end

  assign bus.dout_8b_o   = mem[rptr];
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.count_o     = count;
  assign bus.overflow_o  = overflow;
  assign bus.timeout_o   = timeout;
  assign bus.interrupt_o = irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks every pop.
module tb_uart_rx_fifo;
  localparam int DL2 = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] exp_q [$];

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2 (DL2),
    .THRESH     (8),
    .TIMEOUT_CYC(32'd20)
  ) dut (
    .clk_50m_i(clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT performs a pop, its head byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.rd_en_i && !bus.empty_o && !bus.clr_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_data: got %0h with nothing expected", bus.dout_8b_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.dout_8b_o !== e) begin
          bad++;
          $display("FAIL pop_data: got %0h expected %0h", bus.dout_8b_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    bus.din_8b_i    = b;
    bus.din_valid_i = 1'b1;
    if (accept) exp_q.push_back(b);
    tick();
    bus.din_valid_i = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] b);
    bus.din_8b_i    = b;
    bus.din_valid_i = 1'b1;
    bus.rd_en_i     = 1'b1;
    exp_q.push_back(b);
    tick();
    bus.din_valid_i = 1'b0;
    bus.rd_en_i     = 1'b0;
  endtask

  task automatic pop_n(input int n);
    bus.rd_en_i = 1'b1;
    repeat (n) tick();
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.din_8b_i    = 8'h00;
    bus.din_valid_i = 1'b0;
    bus.rd_en_i     = 1'b0;
    bus.clr_i       = 1'b0;

    #2;
    check("rst_count",    32'(bus.count_o), 32'd0);
    check("rst_empty",    32'(bus.empty_o), 32'd1);
    check("rst_full",     32'(bus.full_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_timeout",  32'(bus.timeout_o), 32'd0);
    check("rst_irq",      32'(bus.interrupt_o), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts a push; bytes spaced 4 cycles apart.
    push(8'h11, 1'b1);
    check("first_push_count", 32'(bus.count_o), 32'd1);
    idle(3);
    push(8'h22, 1'b1);
    idle(3);
    push(8'h33, 1'b1);
    check("three_count", 32'(bus.count_o), 32'd3);
    pop_n(3);
    check("drain3_empty", 32'(bus.empty_o), 32'd1);
    check("drain3_count", 32'(bus.count_o), 32'd0);
    check("drain3_sb",    32'(exp_q.size()), 32'd0);

    pop_n(2);
    check("underflow_count", 32'(bus.count_o), 32'd0);
    check("underflow_empty", 32'(bus.empty_o), 32'd1);
    check("underflow_ovf",   32'(bus.overflow_o), 32'd0);

    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    check("fill_count", 32'(bus.count_o), 32'd16);
    check("fill_full",  32'(bus.full_o), 32'd1);
    check("fill_ovf",   32'(bus.overflow_o), 32'd0);
    push(8'hAA, 1'b0);
    check("drop_ovf",   32'(bus.overflow_o), 32'd1);
    check("drop_full",  32'(bus.full_o), 32'd1);
    check("drop_count", 32'(bus.count_o), 32'd16);
    check("full_irq",   32'(bus.interrupt_o), 32'd1);
    pop_n(16);
    check("drain16_empty", 32'(bus.empty_o), 32'd1);
    check("ovf_sticky",    32'(bus.overflow_o), 32'd1);
    check("drain16_sb",    32'(exp_q.size()), 32'd0);
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    check("clr_ovf", 32'(bus.overflow_o), 32'd0);

    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b1);
    push_pop(8'h55);
    check("pp_full_count", 32'(bus.count_o), 32'd16);
    check("pp_full_ovf",   32'(bus.overflow_o), 32'd0);
    check("pp_full_full",  32'(bus.full_o), 32'd1);
    pop_n(16);
    check("pp_drain_empty", 32'(bus.empty_o), 32'd1);
    check("pp_drain_sb",    32'(exp_q.size()), 32'd0);

    // Simultaneous push/pop at count 1 leaves count unchanged.
    push(8'h5A, 1'b1);
    push_pop(8'h5B);
    check("pp_one_count", 32'(bus.count_o), 32'd1);
    pop_n(1);
    check("pp_one_sb", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 7; i++) push(8'h60 + 8'(i), 1'b1);
    idle(1);
    check("thr7_count", 32'(bus.count_o), 32'd7);
    check("thr7_irq",   32'(bus.interrupt_o), 32'd0);
    push(8'h67, 1'b1);
    check("thr8_count",     32'(bus.count_o), 32'd8);
    check("thr8_irq_early", 32'(bus.interrupt_o), 32'd0);
    tick();
    check("thr8_irq", 32'(bus.interrupt_o), 32'd1);
    pop_n(1);
    check("thr_pop_count", 32'(bus.count_o), 32'd7);
    check("thr_pop_irq_hold", 32'(bus.interrupt_o), 32'd1);
    tick();
    check("thr_pop_irq", 32'(bus.interrupt_o), 32'd0);
    pop_n(7);
    check("thr_drain_sb", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    push(8'h77, 1'b1);
    idle(19);
    check("to_early", 32'(bus.timeout_o), 32'd0);
    idle(1);
    check("to_set", 32'(bus.timeout_o), 32'd1);
    idle(1);
    check("to_irq", 32'(bus.interrupt_o), 32'd1);
    pop_n(1);
    check("to_clr", 32'(bus.timeout_o), 32'd0);
    idle(1);
    check("to_irq_clr", 32'(bus.interrupt_o), 32'd0);
`else
    push(8'h77, 1'b1);
    idle(25);
    check("to_off",     32'(bus.timeout_o), 32'd0);
    check("to_off_irq", 32'(bus.interrupt_o), 32'd0);
    pop_n(1);
`endif
    check("to_sb", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i), 1'b1);
    check("pre_rst_count", 32'(bus.count_o), 32'd5);
    bus.din_8b_i    = 8'h85;
    bus.din_valid_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count_o), 32'd0);
    check("async_rst_empty", 32'(bus.empty_o), 32'd1);
    check("async_rst_irq",   32'(bus.interrupt_o), 32'd0);
    bus.din_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i), 1'b1);
    check("pre_clr_count", 32'(bus.count_o), 32'd5);
    bus.clr_i       = 1'b1;
    bus.rd_en_i     = 1'b1;
    bus.din_valid_i = 1'b1;
    bus.din_8b_i    = 8'hEE;
    tick();
    bus.clr_i       = 1'b0;
    bus.rd_en_i     = 1'b0;
    bus.din_valid_i = 1'b0;
    check("clr_count", 32'(bus.count_o), 32'd0);
    check("clr_empty", 32'(bus.empty_o), 32'd1);
    exp_q.delete();

    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    pop_n(2);
    check("post_clr_sb",    32'(exp_q.size()), 32'd0);
    check("post_clr_empty", 32'(bus.empty_o), 32'd1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
